router_ni: RTL and testbench

Clocked network interface between a processing element and the processor port of a corner/edge router. The transmit side accepts valid/ready words from the PE, builds the routing header from the destination and the node's own coordinates, and launches 2-phase (toggle) req/ack flits into the router's processor input. The receive side takes 2-phase flits from the router's processor output, synchronises them, and presents them to the PE as valid/ready words.

---
 rtl/router_pkg.sv | 31 +++
 rtl/ni_sync2.sv | 24 ++
 rtl/router_ni.sv | 152 +++++++++++++++
 tb/tb_router_ni.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/router_pkg.sv
// Shared types for the router network interface: TX FSM states, flit header
// layout and the header builder used at FIFO write time.
package router_pkg;

  typedef enum logic [1:0] {IDLE, SETUP, SEND, WAIT_ACK} ni_state_t;

  // Coordinates are carried at a fixed maximum width inside the header struct;
  // the top slices them down to XW/YW when packing the flit.
  localparam int unsigned CW_MAX = 16;

  typedef struct packed {
    logic [CW_MAX-1:0] dst_x;
    logic [CW_MAX-1:0] dst_y;
    logic              x_dir;
    logic              y_dir;
  } flit_hdr_t;

  // Direction bits are unsigned "destination is beyond us" comparisons.
  function automatic flit_hdr_t make_header(input logic [CW_MAX-1:0] dx,
                                            input logic [CW_MAX-1:0] dy,
                                            input logic [CW_MAX-1:0] sx,
                                            input logic [CW_MAX-1:0] sy);
    flit_hdr_t h;
    h.dst_x = dx;
    h.dst_y = dy;
    h.x_dir = (dx > sx);
    h.y_dir = (dy > sy);
    return h;
  endfunction

endpackage

// File: rtl/ni_sync2.sv
// Two-flop synchroniser for a single toggle signal crossing in from the router.
module ni_sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic ff1_q, ff2_q;

  // Shift the async input through two flops before anyone looks at it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ff1_q <= 1'b0;
      ff2_q <= 1'b0;
    end else begin
      ff1_q <= d_i;
      ff2_q <= ff1_q;
    end
  end

  assign q_o = ff2_q;

endmodule

// File: rtl/router_ni.sv
// Network interface: PE valid/ready words <-> router 2-phase req/ack flits.
// TX: range-check, header build, small FIFO, launch FSM. RX: sync, capture, hold.
module router_ni import router_pkg::*; #(
  parameter int unsigned n     = 32,
  parameter int unsigned XW    = 1,
  parameter int unsigned YW    = 1,
  parameter int unsigned srcx  = 0,
  parameter int unsigned srcy  = 0,
  parameter int unsigned maxx  = 1,
  parameter int unsigned maxy  = 1,
  parameter int unsigned DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  input  logic [XW-1:0]         tx_dst_x,
  input  logic [YW-1:0]         tx_dst_y,
  input  logic [n-XW-YW-3:0]    tx_payload,
  output logic                  tx_err,
  output logic                  net_out_req,
  output logic [n-1:0]          net_out_data,
  input  logic                  net_out_ack,
  input  logic                  net_in_req,
  input  logic [n-1:0]          net_in_data,
  output logic                  net_in_ack,
  output logic                  rx_valid,
  input  logic                  rx_ready,
  output logic [XW+YW+1:0]      rx_src_hdr,
  output logic [n-XW-YW-3:0]    rx_payload
);

  localparam int unsigned PW = n - XW - YW - 2;
  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  // ---------------- TX write side ----------------
  flit_hdr_t    hdr;
  logic         in_range, push, pop, fifo_empty;
  logic [n-1:0] flit_in;
  logic [n-1:0] mem_q [DEPTH];
  logic [AW:0]  wr_ptr_q, rd_ptr_q, count;
  logic         tx_err_q;

  assign hdr      = make_header(CW_MAX'(tx_dst_x), CW_MAX'(tx_dst_y),
                                CW_MAX'(srcx), CW_MAX'(srcy));
  assign in_range = (hdr.dst_x <= CW_MAX'(maxx)) && (hdr.dst_y <= CW_MAX'(maxy));
  assign flit_in  = {hdr.dst_x[XW-1:0], hdr.dst_y[YW-1:0], hdr.x_dir, hdr.y_dir, tx_payload};

  // Ready comes from the registered count only, so a pop in a full cycle
  // frees the slot for the following cycle, never the same one.
  assign count      = wr_ptr_q - rd_ptr_q;
  assign tx_ready   = (count != FULL_CNT);
  assign fifo_empty = (count == '0);
  assign push       = tx_valid && tx_ready && in_range;

  // FIFO storage; contents need no reset since the pointers gate visibility.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= flit_in;
  end

  // FIFO pointers and the one-cycle drop indication.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      tx_err_q <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      tx_err_q <= tx_valid && tx_ready && !in_range;
    end
  end

  assign tx_err = tx_err_q;

  // ---------------- TX launch FSM ----------------
  ni_state_t    state_q, state_d;
  logic         req_q, ack_s, load_data, toggle_req;
  logic [n-1:0] out_data_q;

  ni_sync2 u_ack_sync (.clk(clk), .rst_n(rst_n), .d_i(net_out_ack), .q_o(ack_s));

  assign pop = load_data;

  // Next state plus the data-load / req-toggle strobes.
  always_comb begin
    state_d    = state_q;
    load_data  = 1'b0;
    toggle_req = 1'b0;
    case (state_q)
      IDLE:     if (!fifo_empty) state_d = SETUP;
      SETUP: begin
        load_data = 1'b1;
        state_d   = SEND;
      end
      SEND: begin
        toggle_req = 1'b1;
        state_d    = WAIT_ACK;
      end
      WAIT_ACK: if (ack_s == req_q) state_d = fifo_empty ? IDLE : SETUP;
      default:  state_d = IDLE;
    endcase
  end

  // State, outgoing data (held until the ack returns) and the req toggle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      req_q      <= 1'b0;
      out_data_q <= '0;
    end else begin
      state_q <= state_d;
      if (load_data)  out_data_q <= mem_q[rd_ptr_q[AW-1:0]];
      if (toggle_req) req_q      <= ~req_q;
    end
  end

  assign net_out_req  = req_q;
  assign net_out_data = out_data_q;

  // ---------------- RX path ----------------
  logic         req_s, in_ack_q, rx_valid_q, pending, capture;
  logic [n-1:0] rx_data_q;

  ni_sync2 u_req_sync (.clk(clk), .rst_n(rst_n), .d_i(net_in_req), .q_o(req_s));

  assign pending = (req_s != in_ack_q);
  assign capture = pending && (!rx_valid_q || rx_ready);

  // Capture a pending flit when the holding register is free or draining;
  // withholding the ack is what back-pressures the router.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_ack_q   <= 1'b0;
      rx_valid_q <= 1'b0;
      rx_data_q  <= '0;
    end else if (capture) begin
      rx_data_q  <= net_in_data;
      rx_valid_q <= 1'b1;
      in_ack_q   <= ~in_ack_q;
    end else if (rx_ready) begin
      rx_valid_q <= 1'b0;
    end
  end

  assign net_in_ack = in_ack_q;
  assign rx_valid   = rx_valid_q;
  assign rx_src_hdr = rx_data_q[n-1:PW];
  assign rx_payload = rx_data_q[PW-1:0];

endmodule

// File: tb/tb_router_ni.sv
// Scoreboard bench for router_ni: a router model acks TX flits and checks them
// against queued expectations; an RX monitor checks words handed to the PE.
module tb_router_ni;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // main DUT: XW=YW=1, PW=28
  logic        tx_valid = 1'b0, tx_ready, tx_err;
  logic [0:0]  tx_dst_x = '0, tx_dst_y = '0;
  logic [27:0] tx_payload = '0;
  logic        net_out_req, net_out_ack = 1'b0;
  logic [31:0] net_out_data;
  logic        net_in_req = 1'b0, net_in_ack;
  logic [31:0] net_in_data = '0;
  logic        rx_valid, rx_ready = 1'b1;
  logic [3:0]  rx_src_hdr;
  logic [27:0] rx_payload;

  // second DUT: XW=2, PW=27, for the out-of-range case
  logic        tx_valid2 = 1'b0, tx_ready2, tx_err2;
  logic [1:0]  tx_dst_x2 = '0;
  logic [0:0]  tx_dst_y2 = '0;
  logic [26:0] tx_payload2 = '0;
  logic        net_out_req2, net_in_ack2, rx_valid2;
  logic [31:0] net_out_data2;
  logic [4:0]  rx_src_hdr2;
  logic [26:0] rx_payload2;

  router_ni #(.n(32), .XW(1), .YW(1), .srcx(0), .srcy(0), .maxx(1), .maxy(1), .DEPTH(4)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_dst_x(tx_dst_x), .tx_dst_y(tx_dst_y),
    .tx_payload(tx_payload), .tx_err(tx_err),
    .net_out_req(net_out_req), .net_out_data(net_out_data), .net_out_ack(net_out_ack),
    .net_in_req(net_in_req), .net_in_data(net_in_data), .net_in_ack(net_in_ack),
    .rx_valid(rx_valid), .rx_ready(rx_ready), .rx_src_hdr(rx_src_hdr), .rx_payload(rx_payload)
  );

  router_ni #(.n(32), .XW(2), .YW(1), .srcx(0), .srcy(0), .maxx(1), .maxy(1), .DEPTH(4)) u_dut2 (
    .clk(clk), .rst_n(rst_n),
    .tx_valid(tx_valid2), .tx_ready(tx_ready2), .tx_dst_x(tx_dst_x2), .tx_dst_y(tx_dst_y2),
    .tx_payload(tx_payload2), .tx_err(tx_err2),
    .net_out_req(net_out_req2), .net_out_data(net_out_data2), .net_out_ack(1'b0),
    .net_in_req(1'b0), .net_in_data(32'h0), .net_in_ack(net_in_ack2),
    .rx_valid(rx_valid2), .rx_ready(1'b1), .rx_src_hdr(rx_src_hdr2), .rx_payload(rx_payload2)
  );

  int nchk = 0, nerr = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  logic [31:0] exp_q[$];   // TX flits expected at the router
  logic [31:0] rx_q[$];    // flits expected at the PE

  // router-side knobs and state
  bit ack_hold = 1'b0;
  int ack_dly  = 1;
  bit router_pend = 1'b0;
  int cyc = 0;

  // Router model: sees each req toggle, checks the flit, acks after a delay.
  initial begin : router_model
    logic        last_req;
    logic [31:0] prev_data;
    int          cnt, last_ack_cyc;
    last_req = 1'b0; prev_data = '0; cnt = 0; last_ack_cyc = -1;
    forever begin
      @(negedge clk); #2;
      cyc++;
      if (!rst_n) begin
        net_out_ack  = 1'b0;
        last_req     = 1'b0;
        router_pend  = 1'b0;
        last_ack_cyc = -1;
      end else begin
        if (net_out_req != last_req) begin
          chk("req_before_ack", router_pend, 1'b0);
          if (last_ack_cyc >= 0) chk("ack_sync_gap", (cyc - last_ack_cyc) >= 5, 1'b1);
          if (exp_q.size() == 0) chk("flit_unexpected", net_out_data, 32'hx);
          else chk("flit", net_out_data, exp_q.pop_front());
          chk("data_setup", net_out_data, prev_data);
          last_req    = net_out_req;
          router_pend = 1'b1;
          cnt         = ack_dly;
        end
        if (router_pend && !ack_hold) begin
          if (cnt == 0) begin
            net_out_ack  = last_req;
            router_pend  = 1'b0;
            last_ack_cyc = cyc;
          end else cnt--;
        end
      end
      prev_data = net_out_data;
    end
  end

  // PE-side RX monitor: each accepted word must match the queue head.
  initial begin : rx_monitor
    forever begin
      @(negedge clk); #2;
      if (rst_n && rx_valid && rx_ready) begin
        if (rx_q.size() == 0) chk("rx_unexpected", {rx_src_hdr, rx_payload}, 32'hx);
        else chk("rx_word", {rx_src_hdr, rx_payload}, rx_q.pop_front());
      end
    end
  end

  int err1 = 0;
  initial forever begin
    @(negedge clk);
    if (tx_err) err1++;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: run did not complete");
    $fatal(1);
  end

  task automatic push(input logic x, input logic y, input logic [27:0] p);
    int g = 0;
    tx_valid = 1'b1; tx_dst_x = x; tx_dst_y = y; tx_payload = p;
    while (!tx_ready && g < 200) begin @(negedge clk); g++; end
    if (g >= 200) chk("push_timeout", tx_ready, 1'b1);
    exp_q.push_back({x, y, x, y, p});  // srcx = srcy = 0: dir bit = (dst != 0)
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  task automatic drain(input int budget);
    int g = 0;
    while ((exp_q.size() != 0 || router_pend) && g < budget) begin @(negedge clk); g++; end
    if (g >= budget) chk("drain_timeout", exp_q.size(), 0);
    repeat (6) @(negedge clk);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_tx_ready", tx_ready, 1'b1);
    chk("rst_req", net_out_req, 1'b0);
    chk("rst_out_data", net_out_data, 32'h0);
    chk("rst_in_ack", net_in_ack, 1'b0);
    chk("rst_rx_valid", rx_valid, 1'b0);
    chk("rst_tx_err", tx_err, 1'b0);
    chk("rst_rx_word", {rx_src_hdr, rx_payload}, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // 1: single flit, req toggles on the third edge after the push
    push(1'b1, 1'b0, 28'hFFFFFFF);
    chk("t1_req_e0", net_out_req, 1'b0);
    @(negedge clk);
    chk("t1_req_e1", net_out_req, 1'b0);
    @(negedge clk);
    chk("t1_data_e2", net_out_data, 32'hAFFFFFFF);
    chk("t1_req_e2", net_out_req, 1'b0);
    @(negedge clk);
    chk("t1_req_e3", net_out_req, 1'b1);
    drain(100);

    // 2: back-to-back with slow ack
    ack_dly = 3;
    push(1'b1, 1'b1, 28'hFFFFFFF);
    push(1'b0, 1'b1, 28'hFFFFFFF);
    push(1'b0, 1'b0, 28'hFFFFFFF);
    drain(300);
    ack_dly = 1;

    // 3: fill with ack withheld, then release
    ack_hold = 1'b1;
    for (int i = 0; i < 5; i++) push(i[0], i[1], 28'h0100 + 28'(i));
    chk("t3_full", tx_ready, 1'b0);
    repeat (5) @(negedge clk);
    chk("t3_still_full", tx_ready, 1'b0);
    chk("t3_queued", exp_q.size(), 4);
    ack_hold = 1'b0;
    drain(400);
    chk("t3_ready_back", tx_ready, 1'b1);

    // 4: out-of-range destination on the XW=2 instance
    begin
      int pulses = 0;
      tx_valid2 = 1'b1; tx_dst_x2 = 2'd2; tx_dst_y2 = 1'b0; tx_payload2 = 27'h1234567;
      chk("t4_ready", tx_ready2, 1'b1);
      @(negedge clk);
      tx_valid2 = 1'b0;
      for (int i = 0; i < 8; i++) begin
        if (tx_err2) pulses++;
        @(negedge clk);
      end
      chk("t4_err_pulses", pulses, 1);
      chk("t4_no_req", net_out_req2, 1'b0);
      tx_valid2 = 1'b1; tx_dst_x2 = 2'd1; tx_dst_y2 = 1'b1; tx_payload2 = 27'h5A5A5A5;
      @(negedge clk);
      tx_valid2 = 1'b0;
      pulses = 0;
      while (!net_out_req2 && pulses < 20) begin @(negedge clk); pulses++; end
      chk("t4_legal_req", net_out_req2, 1'b1);
      chk("t4_legal_flit", net_out_data2, {2'b01, 1'b1, 1'b1, 1'b1, 27'h5A5A5A5});
    end

    // 5: RX with back-pressure
    rx_ready = 1'b0;
    net_in_data = 32'h2EEEEEEE;
    net_in_req = 1'b1;
    rx_q.push_back(32'h2EEEEEEE);
    @(negedge clk);
    chk("t5_valid_k", rx_valid, 1'b0);
    @(negedge clk);
    chk("t5_valid_k1", rx_valid, 1'b0);
    chk("t5_ack_k1", net_in_ack, 1'b0);
    @(negedge clk);
    chk("t5_valid_k2", rx_valid, 1'b1);
    chk("t5_ack_k2", net_in_ack, 1'b1);
    chk("t5_payload", rx_payload, 28'hEEEEEEE);
    chk("t5_hdr", rx_src_hdr, 4'h2);
    net_in_data = 32'h9ABCDEF0;
    net_in_req = 1'b0;
    rx_q.push_back(32'h9ABCDEF0);
    repeat (6) @(negedge clk);
    chk("t5_no_ack_stalled", net_in_ack, 1'b1);
    chk("t5_held_payload", rx_payload, 28'hEEEEEEE);
    rx_ready = 1'b1;
    @(negedge clk);
    chk("t5_ack_second", net_in_ack, 1'b0);
    chk("t5_second_payload", rx_payload, 28'hBCDEF0 | 28'hA000000);
    repeat (3) @(negedge clk);
    chk("t5_rx_drained", rx_valid, 1'b0);
    chk("t5_rx_q", rx_q.size(), 0);

    // 6: reset during WAIT_ACK with an RX word also held
    ack_hold = 1'b1;
    rx_ready = 1'b0;
    net_in_data = 32'h1ABCDEF0;
    net_in_req = 1'b1;
    push(1'b1, 1'b1, 28'h3C3C3C3);
    begin
      int g = 0;
      while (exp_q.size() != 0 && g < 30) begin @(negedge clk); g++; end
      chk("t6_in_flight", router_pend, 1'b1);
    end
    chk("t6_rx_held", rx_valid, 1'b1);
    #3 rst_n = 1'b0;
    #1;
    chk("t6_rst_req", net_out_req, 1'b0);
    chk("t6_rst_data", net_out_data, 32'h0);
    chk("t6_rst_ready", tx_ready, 1'b1);
    chk("t6_rst_rx_valid", rx_valid, 1'b0);
    chk("t6_rst_in_ack", net_in_ack, 1'b0);
    chk("t6_rst_rx_word", {rx_src_hdr, rx_payload}, 32'h0);
    chk("t6_rst_err", tx_err, 1'b0);
    net_in_req = 1'b0;
    ack_hold = 1'b0;
    rx_ready = 1'b1;
    rx_q.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    push(1'b1, 1'b0, 28'hFFFFFFF);
    drain(100);
    chk("t6_req_after", net_out_req, 1'b1);

    chk("no_spurious_err", err1, 0);
    chk("exp_q_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
